// File: rtl/decoder8_rr_arbiter_if.sv
// ============================================================================
// Module      : decoder8_rr_arbiter_if
// Description : Request/grant bus between eight requesters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decoder8_rr_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       gnt_vld;
    logic       timeout;

    // Requester side
    modport master (
        output req,
        output done,
        input  gnt_idx,
        input  gnt,
        input  gnt_vld,
        input  timeout
    );

    // Arbiter side
    modport slave (
        input  req,
        input  done,
        output gnt_idx,
        output gnt,
        output gnt_vld,
        output timeout
    );
endinterface

`default_nettype wire

// File: rtl/decoder8_rr_arbiter.sv
// ============================================================================
// Module      : decoder8_rr_arbiter
// Description : 8-way round-robin arbiter driving a 3-to-8 decoder select,
//               with a one-cycle dead time between grants. Define
//               DECODER8_ARB_TIMEOUT_EN to build the grant watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder8_rr_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    decoder8_rr_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    logic [1:0] r_state;
    logic [2:0] r_last;
    logic [2:0] r_gnt_idx;
    logic [7:0] r_gnt;
    logic       r_gnt_vld;

    logic [2:0] w_win;
    logic [2:0] w_cand;
    logic       w_any_req;
    logic       w_release;
    logic       w_expire;

    // Walk downward from the farthest candidate so the nearest set bit
    // after r_last is the one left standing.
    always_comb begin
        w_win  = r_last;
        w_cand = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            w_cand = r_last + 3'(k);
            if (bus.req[w_cand]) begin
                w_win = w_cand;
            end
        end
    end

    assign w_any_req = |bus.req;
    assign w_release = bus.done | ~bus.req[r_gnt_idx];

`ifdef DECODER8_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_timeout;

    // A natural release in the final cycle wins over the watchdog.
    assign w_expire = (r_cnt == 8'(TIMEOUT_CYCLES - 1)) & ~w_release;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (r_state == S_GRANT) & w_expire;
            if (r_state == S_GRANT) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_expire    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_last    <= 3'b111;
            r_gnt_idx <= 3'b000;
            r_gnt     <= 8'h00;
            r_gnt_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RELEASE: begin
                    if (w_any_req) begin
                        r_state   <= S_GRANT;
                        r_gnt_idx <= w_win;
                        r_gnt     <= 8'h01 << w_win;
                        r_gnt_vld <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (w_release | w_expire) begin
                        r_state   <= S_RELEASE;
                        r_last    <= r_gnt_idx;
                        r_gnt     <= 8'h00;
                        r_gnt_vld <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_gnt     <= 8'h00;
                    r_gnt_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_idx = r_gnt_idx;
    assign bus.gnt     = r_gnt;
    assign bus.gnt_vld = r_gnt_vld;

endmodule

`default_nettype wire

// File: tb/tb_decoder8_rr_arbiter.sv
// ============================================================================
// Module      : tb_decoder8_rr_arbiter
// Description : Self-checking bench for decoder8_rr_arbiter with a
//               behavioural round-robin model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder8_rr_arbiter;

    localparam int TO_CYC = 4;
`ifdef DECODER8_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    decoder8_rr_arbiter_if bus();

    decoder8_rr_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: m_cur is the requester holding the grant, -1 if none.
    int m_cur  = -1;
    int m_idx  = 0;
    int m_last = 7;
    int m_cnt  = 0;
    bit m_to   = 1'b0;

    function automatic int pick(logic [7:0] r, int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur = -1; m_idx = 0; m_last = 7; m_cnt = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_cur >= 0) begin
                bit rel;
                bit expd;
                rel  = bus.done || !bus.req[m_cur];
                expd = TO_EN && (m_cnt == TO_CYC - 1) && !rel;
                if (rel || expd) begin
                    m_last = m_cur;
                    m_cur  = -1;
                    m_to   = expd;
                end else begin
                    m_cnt++;
                end
            end else if (bus.req != 8'h00) begin
                m_cur = pick(bus.req, m_last);
                m_idx = m_cur;
                m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e_gnt;
        e_gnt = (m_cur >= 0) ? (8'h01 << m_cur) : 8'h00;
        chk("model_gnt",     {24'd0, bus.gnt},     {24'd0, e_gnt});
        chk("model_gnt_vld", {31'd0, bus.gnt_vld}, {31'd0, (m_cur >= 0)});
        chk("model_gnt_idx", {29'd0, bus.gnt_idx}, 32'(m_idx));
        chk("model_timeout", {31'd0, bus.timeout}, {31'd0, m_to});
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        step(1);
        bus.done = 1'b0;
    endtask

    initial begin
        bus.req  = 8'h00;
        bus.done = 1'b0;
        step(2);
        chk("reset_gnt", {24'd0, bus.gnt}, 32'h00);
        chk("reset_idx", {29'd0, bus.gnt_idx}, 32'h0);
        rst_n = 1'b1;

        // Single requester, latency and release
        bus.req = 8'h01;
        step(1);
        chk("first_gnt", {24'd0, bus.gnt}, 32'h01);
        chk("first_vld", {31'd0, bus.gnt_vld}, 32'h1);
        bus.req = 8'h00;
        pulse_done();
        chk("first_rel", {24'd0, bus.gnt}, 32'h00);
        step(1);

        // Full rotation from a fresh reset
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        bus.req = 8'hFF;
        step(1);
        for (int i = 0; i < 9; i++) begin
            chk("rr_seq", {24'd0, bus.gnt}, 32'h1 << (i % 8));
            if (i == 8) bus.req = 8'h00;
            pulse_done();
            chk("rr_dead", {31'd0, bus.gnt_vld}, 32'h0);
            if (i < 8) step(1);
        end
        step(1);

        // Wrap-around: 2 -> 7 -> 2
        bus.req = 8'h04;
        step(1);
        chk("wrap_g2", {24'd0, bus.gnt}, 32'h04);
        bus.req = 8'h84;
        pulse_done();
        step(1);
        chk("wrap_g7", {24'd0, bus.gnt}, 32'h80);
        bus.req = 8'h04;
        pulse_done();
        step(1);
        chk("wrap_g2b", {24'd0, bus.gnt}, 32'h04);
        bus.req = 8'h00;
        pulse_done();
        step(1);

        // Drop and done together: single advance past 5
        bus.req = 8'h20;
        step(1);
        chk("dual_g5", {29'd0, bus.gnt_idx}, 32'h5);
        bus.req = 8'h41;
        pulse_done();
        chk("dual_dead", {24'd0, bus.gnt}, 32'h00);
        chk("dual_idx_hold", {29'd0, bus.gnt_idx}, 32'h5);
        step(1);
        chk("dual_g6", {24'd0, bus.gnt}, 32'h40);
        bus.req = 8'h00;
        pulse_done();
        step(1);

        // Stray done while idle
        pulse_done();
        chk("stray_done", {31'd0, bus.gnt_vld}, 32'h0);
        step(1);

        // Asynchronous reset in the middle of a grant
        bus.req = 8'h10;
        step(1);
        chk("rst_g4", {24'd0, bus.gnt}, 32'h10);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_drop", {24'd0, bus.gnt}, 32'h00);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("rst_regrant", {24'd0, bus.gnt}, 32'h10);
        bus.req = 8'h00;
        step(2);

        // Watchdog (or unbounded grant without it)
        bus.req = 8'h08;
        step(1);
        chk("to_g3", {24'd0, bus.gnt}, 32'h08);
        bus.req = 8'h28;
        step(3);
        chk("to_c4", {24'd0, bus.gnt}, 32'h08);
        step(1);
        chk("to_c5_gnt", {24'd0, bus.gnt}, TO_EN ? 32'h00 : 32'h08);
        chk("to_c5_pulse", {31'd0, bus.timeout}, TO_EN ? 32'h1 : 32'h0);
        step(1);
        chk("to_c6_gnt", {24'd0, bus.gnt}, TO_EN ? 32'h20 : 32'h08);
        bus.req = 8'h00;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
